// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared types and parameter checks for the pulse stretcher.
//   ps_state_e  - per-channel FSM state (IDLE / HOLD / GAP)
//   cnt_w_ok()  - true when the counter width holds max(STRETCH,GAP)-1
//                 and both lengths are at least 1
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } ps_state_e;

  function automatic bit cnt_w_ok(input int stretch, input int gap, input int w);
    int mx;
    mx = (stretch > gap) ? stretch : gap;
    return (stretch >= 1) && (gap >= 1) && (w >= 1) && (w < 31) &&
           ((mx - 1) < (1 << w));
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: one channel of the stretcher.
//   clk_i   - stretch clock
//   rst_ni  - async active-low reset
//   req_ni  - request, active-low, synchronous to clk_i
//   out_no  - stretched pulse, active-low, registered
// Optional feature: PULSE_STRETCH_RETRIGGER_EN - a request seen in HOLD
// reloads the stretch counter instead of being dropped.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int STRETCH_LENGTH  = 8,
  parameter int GAP_LENGTH      = 4,
  parameter int COUNT_BIT_WIDTH = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_ni,
  output logic out_no
);

  localparam logic [COUNT_BIT_WIDTH-1:0] S_RELOAD = COUNT_BIT_WIDTH'(STRETCH_LENGTH - 1);
  localparam logic [COUNT_BIT_WIDTH-1:0] G_RELOAD = COUNT_BIT_WIDTH'(GAP_LENGTH - 1);

  ps_state_e                  state_q, state_d;
  logic [COUNT_BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       out_q, out_d;
  logic                       req;
  logic                       retrig;

  assign req = ~req_ni;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  assign retrig = req;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = S_RELOAD;
        end
      end
      HOLD: begin
        // Retrigger wins over the count==0 exit so a request on the last
        // low cycle still extends the pulse.
        if (retrig) begin
          cnt_d = S_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = G_RELOAD;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_q || req) begin
            state_d = HOLD;
            cnt_d   = S_RELOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (req) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    // Output registered off the next state so the pulse starts on the same
    // edge that samples the request.
    out_d = (state_d != HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign out_no = out_q;

endmodule

// File: rtl/pulse_stretch_vector.sv
// pulse_stretch_vector: SIGNAL_BIT_WIDTH independent pulse stretchers.
//   clk_stretch         - stretch clock
//   reset_n             - async active-low reset
//   signals_n           - request pulses, active-low
//   signals_stretched_n - stretched pulses, active-low, registered
// Optional feature: PULSE_STRETCH_RETRIGGER_EN (see pulse_stretch).
module pulse_stretch_vector
  import pulse_stretch_pkg::*;
#(
  parameter int SIGNAL_BIT_WIDTH = 1,
  parameter int STRETCH_LENGTH   = 8,
  parameter int GAP_LENGTH       = 4,
  parameter int COUNT_BIT_WIDTH  = 3
) (
  input  logic                        clk_stretch,
  input  logic                        reset_n,
  input  logic [SIGNAL_BIT_WIDTH-1:0] signals_n,
  output logic [SIGNAL_BIT_WIDTH-1:0] signals_stretched_n
);

  if (!cnt_w_ok(STRETCH_LENGTH, GAP_LENGTH, COUNT_BIT_WIDTH)) begin : g_bad_param
    $error("pulse_stretch_vector: illegal STRETCH_LENGTH/GAP_LENGTH/COUNT_BIT_WIDTH");
  end

  for (genvar i = 0; i < SIGNAL_BIT_WIDTH; i++) begin : g_ch
    pulse_stretch #(
      .STRETCH_LENGTH (STRETCH_LENGTH),
      .GAP_LENGTH     (GAP_LENGTH),
      .COUNT_BIT_WIDTH(COUNT_BIT_WIDTH)
    ) u_ch (
      .clk_i (clk_stretch),
      .rst_ni(reset_n),
      .req_ni(signals_n[i]),
      .out_no(signals_stretched_n[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretch_vector.sv
module tb_pulse_stretch_vector;

  localparam int NW = 4;
  localparam int S  = 8;
  localparam int G  = 4;

  logic          clk_stretch = 1'b0;
  logic          reset_n     = 1'b0;
  logic [NW-1:0] signals_n   = '1;
  logic [NW-1:0] signals_stretched_n;

  int n_chk = 0;
  int n_err = 0;

  // Reference: each channel is described by its current/scheduled pulse
  // window [s, e) in edge numbers; output is low iff s <= t < e.
  int t;
  int s_t[NW];
  int e_t[NW];

  pulse_stretch_vector #(
    .SIGNAL_BIT_WIDTH(NW),
    .STRETCH_LENGTH  (S),
    .GAP_LENGTH      (G),
    .COUNT_BIT_WIDTH (3)
  ) dut (
    .clk_stretch        (clk_stretch),
    .reset_n            (reset_n),
    .signals_n          (signals_n),
    .signals_stretched_n(signals_stretched_n)
  );

  always #5 clk_stretch = ~clk_stretch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      s_t[i] = -1000;
      e_t[i] = -1000;
    end
  endtask

  // Request sampled at edge t. The channel is in HOLD for request purposes
  // on edges s+1..e, in GAP on edges e+1..e+G.
  task automatic model_edge(input logic [NW-1:0] req_n);
    for (int i = 0; i < NW; i++) begin
      if (!req_n[i]) begin
        if (t <= s_t[i]) begin
          // next pulse already queued
        end else if (t <= e_t[i]) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          e_t[i] = t + S;
`endif
        end else if (t < e_t[i] + G) begin
          s_t[i] = e_t[i] + G;
          e_t[i] = s_t[i] + S;
        end else begin
          s_t[i] = t;
          e_t[i] = t + S;
        end
      end
    end
  endtask

  function automatic logic [NW-1:0] model_out();
    logic [NW-1:0] o;
    for (int i = 0; i < NW; i++) o[i] = !((s_t[i] <= t) && (t < e_t[i]));
    return o;
  endfunction

  // Called at a negedge: drive, clock, then compare at the next negedge.
  task automatic step(input logic [NW-1:0] req_n, input string tag);
    signals_n = req_n;
    @(posedge clk_stretch);
    t++;
    model_edge(req_n);
    @(negedge clk_stretch);
    chk(tag, 32'(signals_stretched_n), 32'(model_out()));
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step('1, tag);
  endtask

  task automatic do_reset();
    signals_n = '1;
    reset_n   = 1'b0;
    #1;
    chk("async_rst", 32'(signals_stretched_n), 32'hF);
    model_reset();
    @(posedge clk_stretch);
    @(negedge clk_stretch);
    chk("rst_hold", 32'(signals_stretched_n), 32'hF);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NW-1:0] req;
    int            burst[NW];
    t = 0;
    model_reset();
    repeat (3) @(posedge clk_stretch);
    @(negedge clk_stretch);
    chk("reset", 32'(signals_stretched_n), 32'hF);
    reset_n = 1'b1;

    idle(9, "quiet");
    // single 1-cycle request on bit0
    step(4'hE, "b0_single");
    idle(14, "b0_single");
    // bit1 held low 30 cycles
    for (int k = 0; k < 30; k++) step(4'hD, "b1_held");
    idle(14, "b1_tail");
    // bit2 request, then a second one landing in GAP cycle 2 -> pending
    step(4'hB, "b2_first");
    idle(9, "b2_first");
    step(4'hB, "b2_pend");
    idle(16, "b2_second");
    // reset in the middle of a HOLD on bit0
    step(4'hE, "b0_pre_rst");
    idle(3, "b0_pre_rst");
    do_reset();
    idle(4, "post_rst");
    step(4'hE, "b0_after_rst");
    idle(12, "b0_after_rst");
    // bits 0 and 3 five cycles apart
    step(4'hE, "b0_b3");
    idle(4, "b0_b3");
    step(4'h7, "b0_b3");
    idle(16, "b0_b3");

    // randomized bursts of varying length per bit, with rare resets
    for (int i = 0; i < NW; i++) burst[i] = 0;
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        for (int i = 0; i < NW; i++) burst[i] = 0;
      end
      for (int i = 0; i < NW; i++) begin
        if (burst[i] == 0 && $urandom_range(0, 5) == 0)
          burst[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                                 : int'($urandom_range(1, 2));
        req[i] = (burst[i] == 0);
        if (burst[i] > 0) burst[i]--;
      end
      step(req, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
